usb_dfu_boot_ctrl: RTL

- Sits directly downstream of usb_dfu_core. Consumes the protocol engine's SOF strobe and frame index plus DFU control-endpoint events.
- Decides when the bootloader hands off to the user image:
  - tracks host presence from SOF traffic;
  - executes the DFU detach/manifest sequence (USB disconnect, settle delay, warmboot pulse);
  - drives the iCE40 warmboot primitive and the USB pull-up enable.

---
 rtl/usb_dfu_boot_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/usb_dfu_boot_ctrl.sv
// DFU bootloader hand-off controller: SOF-based host presence, detach/disconnect/warmboot sequencing.
// Optional auto-boot without a host is enabled by defining USB_BOOT_TIMEOUT_EN.
module usb_dfu_boot_ctrl #(
  parameter int unsigned CLK_HZ              = 48000000,
  parameter int unsigned PRESENCE_TIMEOUT_MS = 1000,
  parameter int unsigned DISCONNECT_MS       = 10,
  parameter logic [1:0]  BOOT_IMAGE          = 2'b01,
  parameter int unsigned BOOT_PULSE_CYCLES   = 4,
  parameter int unsigned BOOT_TIMEOUT_MS     = 5000
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic        sof_valid,
  input  logic [10:0] frame_index,
  input  logic        dfu_detach,
  input  logic        dfu_busy,
  output logic        usb_pullup_en,
  output logic        boot_en,
  output logic [1:0]  boot_sel,
  output logic        host_present,
  output logic        frame_gap,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ACTIVE      = 3'd1,
    DETACH_WAIT = 3'd2,
    DISCONNECT  = 3'd3,
    BOOT        = 3'd4,
    HALT        = 3'd5
  } state_t;

  localparam logic [31:0] PRESC_MAX = 32'(CLK_HZ / 1000 - 1);
  localparam int          CW        = $clog2(BOOT_PULSE_CYCLES) + 1;

  state_t          state, state_next;
  logic [31:0]     presc;
  logic [15:0]     ms_cnt;
  logic [CW-1:0]   cyc_cnt;
  logic [10:0]     last_frame;
  logic            first_sof;
  logic            ms_tick;
  logic            state_change;
  logic            ms_clr;
  logic            auto_boot;

  assign ms_tick      = (presc == PRESC_MAX);
  assign state_change = (state_next != state);
  // A SOF restarts the ms timebase too, so the presence timeout is never short.
  assign ms_clr       = sof_valid && (state == IDLE || state == ACTIVE);
  assign state_dbg    = state;

`ifdef USB_BOOT_TIMEOUT_EN
  logic [15:0] boot_to_cnt;
  logic        sof_seen;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      boot_to_cnt <= 16'd0;
      sof_seen    <= 1'b0;
    end else begin
      if (sof_valid) sof_seen <= 1'b1;
      if (!sof_seen && ms_tick && boot_to_cnt != 16'hFFFF)
        boot_to_cnt <= boot_to_cnt + 16'd1;
    end
  end

  assign auto_boot = !sof_seen && !sof_valid && (boot_to_cnt >= 16'(BOOT_TIMEOUT_MS));
`else
  assign auto_boot = 1'b0;
`endif

  always_comb begin
    state_next    = state;
    usb_pullup_en = 1'b1;
    boot_en       = 1'b0;
    boot_sel      = 2'b00;
    case (state)
      IDLE: begin
        if (dfu_detach || auto_boot) state_next = DETACH_WAIT;
        else if (sof_valid)          state_next = ACTIVE;
      end
      ACTIVE: begin
        if (dfu_detach) state_next = DETACH_WAIT;
        else if (!sof_valid && ms_cnt >= 16'(PRESENCE_TIMEOUT_MS)) state_next = IDLE;
      end
      DETACH_WAIT: begin
        if (!dfu_busy) state_next = DISCONNECT;
      end
      DISCONNECT: begin
        usb_pullup_en = 1'b0;
        if (ms_cnt >= 16'(DISCONNECT_MS)) state_next = BOOT;
      end
      BOOT: begin
        usb_pullup_en = 1'b0;
        boot_en       = 1'b1;
        boot_sel      = BOOT_IMAGE;
        if (cyc_cnt == CW'(BOOT_PULSE_CYCLES - 1)) state_next = HALT;
      end
      HALT: begin
        usb_pullup_en = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= 32'd0;
      ms_cnt       <= 16'd0;
      cyc_cnt      <= '0;
      last_frame   <= 11'd0;
      first_sof    <= 1'b1;
      host_present <= 1'b0;
      frame_gap    <= 1'b0;
    end else begin
      state <= state_next;

      if (state_change || ms_clr || ms_tick) presc <= 32'd0;
      else                                   presc <= presc + 32'd1;

      if (state_change || ms_clr)             ms_cnt <= 16'd0;
      else if (ms_tick && ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;

      if (state == BOOT) cyc_cnt <= cyc_cnt + CW'(1);
      else               cyc_cnt <= '0;

      // Presence only changes on IDLE/ACTIVE transitions; the detach path holds it.
      if (state_next == ACTIVE && state != ACTIVE) host_present <= 1'b1;
      else if (state_next == IDLE)                 host_present <= 1'b0;

      if (sof_valid) begin
        last_frame <= frame_index;
        if (state == ACTIVE && !first_sof && frame_index != last_frame + 11'd1)
          frame_gap <= 1'b1;
      end

      if (state_next == IDLE && state != IDLE) first_sof <= 1'b1;
      else if (sof_valid)                      first_sof <= 1'b0;
    end
  end

endmodule
